// File: rtl/quad_step_decoder.sv
// Quadrature front end: 2-FF sync, per-channel stability filter, Gray decoder.
// Ports: clk, reset (sync, active-high), a_in/b_in (async) -> step, up, err, err_flag.
module quad_step_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic up,
  output logic err,
  output logic err_flag
);

  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES - 1);
  localparam logic [8:0] SETTLE_MAX = 9'(STABLE_CYCLES + 2);

  // Bit 1 is channel A, bit 0 is channel B.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] filt_q, filt_d;
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];
  logic [1:0] prev_q, prev_d;
  logic [8:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic       step_q, step_d;
  logic       up_q, up_d;
  logic       err_q, err_d;
  logic       err_flag_q, err_flag_d;

  // Reflected-Gray to binary position: {b,a} is Gray, so the
  // up sequence 00,10,11,01 maps to positions 0,1,2,3.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    gray_pos = {ab[0], ab[0] ^ ab[1]};
  endfunction

  logic [1:0] diff;

  always_comb begin
    sync1_d    = {a_in, b_in};
    sync2_d    = sync1_q;
    filt_d     = filt_q;
    cnt_d[0]   = cnt_q[0];
    cnt_d[1]   = cnt_q[1];
    prev_d     = filt_q;
    settle_d   = settle_q;
    armed_d    = armed_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    up_d       = up_q;
    err_flag_d = err_flag_q;

    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = 8'd0;
      end
    end

    // armed takes effect on the edge after the settle window,
    // so a transition filtered during settling is swallowed.
    if (!armed_q) begin
      if (settle_q == SETTLE_MAX) begin
        armed_d = 1'b1;
      end else begin
        settle_d = settle_q + 9'd1;
      end
    end

    diff = gray_pos(filt_q) - gray_pos(prev_q);
    if (armed_q) begin
      unique case (diff)
        2'd1: begin
          step_d = 1'b1;
          up_d   = 1'b1;
        end
        2'd3: begin
          step_d = 1'b1;
          up_d   = 1'b0;
        end
        2'd2: begin
          err_d      = 1'b1;
          err_flag_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      filt_q     <= 2'b00;
      cnt_q[0]   <= 8'd0;
      cnt_q[1]   <= 8'd0;
      prev_q     <= 2'b00;
      settle_q   <= 9'd0;
      armed_q    <= 1'b0;
      step_q     <= 1'b0;
      up_q       <= 1'b1;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      prev_q     <= prev_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      step_q     <= step_d;
      up_q       <= up_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign step     = step_q;
  assign up       = up_q;
  assign err      = err_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: directed table,
// latency sequences and random stimulus against a position-based model.
module tb_quad_step_decoder;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic step, up, err, err_flag;

  quad_step_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .step(step), .up(up), .err(err), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position around the cycle 00->10->11->01 (index {a,b}).
  localparam int POS_TAB [4] = '{0, 3, 1, 2};
  bit [1:0] m_s1, m_s2, m_f;
  int m_run [2];
  int m_prev;
  int m_edges;
  bit m_step, m_up, m_err, m_flag;

  int sc, ec, tb_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_f = 0;
      m_run[0] = 0; m_run[1] = 0;
      m_prev = 0; m_edges = 0;
      m_step = 0; m_err = 0; m_flag = 0; m_up = 1;
    end else begin
      d = (POS_TAB[m_f] - m_prev + 4) % 4;
      m_step = 0;
      m_err = 0;
      if (m_edges >= S + 3) begin
        if (d == 1) begin m_step = 1; m_up = 1; end
        else if (d == 3) begin m_step = 1; m_up = 0; end
        else if (d == 2) begin m_err = 1; m_flag = 1; end
      end
      m_prev = POS_TAB[m_f];
      for (int c = 0; c < 2; c++) begin
        if (m_s2[c] != m_f[c]) begin
          if (m_run[c] == S - 1) begin
            m_f[c] = m_s2[c];
            m_run[c] = 0;
          end else begin
            m_run[c]++;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {a_in, b_in};
      if (m_edges < 1000) m_edges++;
    end
  endtask

  task automatic tick();
    bit was_rst;
    @(posedge clk);
    was_rst = reset;
    model_edge();
    @(negedge clk);
    chk("model_step", int'(step), int'(m_step));
    chk("model_up", int'(up), int'(m_up));
    chk("model_err", int'(err), int'(m_err));
    chk("model_flag", int'(err_flag), int'(m_flag));
    if (step && err) chk("step_err_excl", 1, 0);
    sc += int'(step);
    ec += int'(err);
    if (was_rst) tb_cnt = 0;
    else if (step) tb_cnt += up ? 1 : -1;
  endtask

  typedef struct {
    bit rst; bit a; bit b; int hold;
    int steps; int errs; bit up; bit flag; int cnt;
  } vec_t;

  vec_t tbl [$];

  initial begin
    tb_cnt = 0;
    // rst a b hold steps errs up flag cnt
    tbl.push_back('{1, 1, 1,  2, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 1, 20, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0,  2, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 10, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 10, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 1, 1, 10, 1, 0, 1, 0, 2});
    tbl.push_back('{0, 0, 1, 10, 1, 0, 1, 0, 3});
    tbl.push_back('{0, 0, 0, 10, 1, 0, 1, 0, 4});
    tbl.push_back('{0, 0, 1, 10, 1, 0, 0, 0, 3});
    tbl.push_back('{0, 1, 1, 10, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 1, 0, 10, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 10, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  3, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  5, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 12, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 10, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 10, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 0,  3, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 0,  1, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 12, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 10, 1, 0, 1, 0, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      a_in = tbl[i].a;
      b_in = tbl[i].b;
      sc = 0;
      ec = 0;
      repeat (tbl[i].hold) tick();
      chk($sformatf("v%0d_steps", i), sc, tbl[i].steps);
      chk($sformatf("v%0d_errs", i), ec, tbl[i].errs);
      chk($sformatf("v%0d_up", i), int'(up), int'(tbl[i].up));
      chk($sformatf("v%0d_flag", i), int'(err_flag), int'(tbl[i].flag));
      chk($sformatf("v%0d_cnt", i), tb_cnt, tbl[i].cnt);
    end

    // Step latency: 10 -> 11, pulse exactly after edge 7.
    a_in = 1; b_in = 1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("lat_step_e%0d", e), int'(step), int'(e == S + 3));
      chk($sformatf("lat_err_e%0d", e), int'(err), 0);
    end
    // Illegal 11 -> 00: err after edge 7, flag sticky.
    a_in = 0; b_in = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("ill_err_e%0d", e), int'(err), int'(e == S + 3));
      chk($sformatf("ill_step_e%0d", e), int'(step), 0);
      if (e >= S + 3) chk($sformatf("ill_flag_e%0d", e), int'(err_flag), 1);
    end
    // Reset while a step is about to fire: dropped, outputs at reset.
    a_in = 1;
    repeat (S + 2) tick();
    reset = 1;
    tick();
    chk("rst_step", int'(step), 0);
    chk("rst_flag", int'(err_flag), 0);
    chk("rst_up", int'(up), 1);
    reset = 0;
    a_in = 0;
    repeat (12) tick();

    // Random segments, checked every cycle against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1;
        repeat ($urandom_range(1, 2)) tick();
        reset = 0;
      end else begin
        a_in = 1'($urandom);
        b_in = 1'($urandom);
        repeat ($urandom_range(1, 12)) tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
